frame_update_scheduler: RTL and testbench
=========================================

Name: frame_update_scheduler

Overview:
- Sequences the per-frame game-logic update so that all game-state changes happen during vertical blanking.
- Consumes the VGA timer's pixel position and detects the start of vblank.
- Then grants an update slot to each game-object client in turn (dino, obstacles, ground, score) through a req/ack handshake.
- Reports overruns when a client update is still pending as the next visible frame begins.

Parameters:
- NUM_CLIENTS, 4, number of update clients; index width CW = max(1, clog2(NUM_CLIENTS)).
- FRAME_DIV, 1, a tick is issued every FRAME_DIV vblank starts; must be >= 1.
- TIMEOUT, 1024, cycles to wait for one client's ack before skipping it; must be >= 2.
- VIS_Y, 480, first non-visible line.

Ports:
- clk_i  in  1  pixel clock (25.175 MHz domain)
- rst_i  in  1  synchronous, active-high reset
- position_x_i  in  10  current horizontal counter from the timer
- position_y_i  in  10  current vertical counter from the timer
- run_i  in  1  game running; 0 = paused, no updates issued
- update_req_o  out  NUM_CLIENTS  one-hot update request, held until ack or abort
- update_ack_i  in  NUM_CLIENTS  client done; only the bit of the active client is honoured
- client_idx_o  out  CW  index of the active client (0 when idle)
- frame_tick_o  out  1  1-cycle pulse, coincident with the first cycle of update_req_o[0]
- busy_o  out  1  high in SERVE state
- timeout_o  out  1  1-cycle pulse when a client is skipped
- overrun_o  out  1  1-cycle pulse when a sequence is aborted at visible start
- frame_count_o  out  16  count of vblank starts, wraps 0xFFFF->0

Behaviour:
- Events, decoded combinationally from the inputs:
  - vb_start = (position_x_i==0 && position_y_i==VIS_Y).
  - vis_start = (position_x_i==0 && position_y_i==0).
- Reset (rst_i=1 at a clock edge):
  - All outputs 0: req, idx, tick, busy, timeout, overrun, frame_count.
  - State IDLE; div_cnt=0; to_cnt=0.
  - Reset mid-sequence drops req in the next cycle; no pulse is emitted.
- frame_count_o increments on every vb_start, regardless of run_i or state.
- Divider:
  - On vb_start with run_i=1: if div_cnt==FRAME_DIV-1, fire and set div_cnt=0; else div_cnt++.
  - While run_i=0, div_cnt is forced to 0.
- FSM states IDLE and SERVE:
  - IDLE -> SERVE on fire. In the next cycle: idx=0, update_req_o=1<<0, frame_tick_o=1, busy_o=1, to_cnt=0. Latency is 1 cycle from vb_start.
  - SERVE, update_ack_i[idx]=1: update_req_o drops next cycle. If idx<NUM_CLIENTS-1, then idx++, req moves to the new idx in that same next cycle, and to_cnt=0. If idx is the last client, go to IDLE (idx=0, busy=0). There are no idle cycles between clients.
  - SERVE, no ack: to_cnt++. When to_cnt==TIMEOUT-1 without an ack, timeout_o pulses next cycle and the FSM advances exactly as for an ack (skip).
  - Ack and timeout expiry in the same cycle: the ack wins and no timeout pulse is emitted.
  - Ack bits for non-active clients are ignored in all states.
  - SERVE, vis_start: abort. Next cycle: overrun_o=1, req=0, idx=0, IDLE. vis_start has priority over a same-cycle ack or timeout.
- Pause: run_i falling during SERVE does not abort; the current sequence completes.
- update_req_o is never multi-hot. It is all-zero whenever busy_o=0.
- All outputs are registered.

Test Plan:
- Reset and basic sequence, NUM_CLIENTS=4, run_i=1, drive y=480/x=0, ack each client 3 cycles after its req rises:
  - frame_tick_o and req=0001 one cycle after vb_start.
  - req sequence 0001, 0010, 0100, 1000 with no gaps.
  - busy_o drops after the 4th ack; frame_count_o=1.
- Divider, FRAME_DIV=3, 7 vb_starts with run_i=1 -> frame_tick_o pulses after the 3rd and 6th only; frame_count_o=7.
- Timeout, TIMEOUT=16, client 1 never acks -> timeout_o pulses once, 16 cycles after req=0010 rose; req then moves to 0100; the sequence completes.
- Overrun: client 2 held without ack, TIMEOUT large, drive y=0/x=0 -> overrun_o pulse next cycle, req=0000, busy_o=0.
- Simultaneous events:
  - Ack on the cycle to_cnt==TIMEOUT-1 -> no timeout_o.
  - Ack concurrent with vis_start -> overrun_o=1.
  - Stray ack on an inactive bit -> no advance.
- Pause and reset:
  - run_i=0 at vb_start -> no tick; frame_count_o still increments.
  - rst_i asserted mid-SERVE -> all outputs 0 next cycle, no pulses.

Source files
------------

// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler
// Sequences per-frame game-logic updates into vertical blanking. On every
// FRAME_DIV-th start of vblank (while running) each client is granted an
// update slot in turn through a one-hot req/ack handshake. A client that does
// not ack within TIMEOUT cycles is skipped; a sequence still in progress when
// the next visible frame starts is aborted and reported as an overrun.
//
// Ports:
//   clk_i, rst_i        pixel clock, synchronous active-high reset
//   position_x_i/_y_i   current pixel position from the VGA timer
//   run_i               game running; no new sequence starts while low
//   update_req_o        one-hot request to the active client
//   update_ack_i        client done (only the active client's bit is used)
//   client_idx_o        index of the active client, 0 when idle
//   frame_tick_o        pulse on the first cycle of a sequence
//   busy_o              sequence in progress
//   timeout_o           pulse when a client is skipped
//   overrun_o           pulse when a sequence is aborted at visible start
//   frame_count_o       free-running count of vblank starts
module frame_update_scheduler #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned FRAME_DIV   = 1,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned VIS_Y       = 480,
    localparam int unsigned CW         = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [9:0]             position_x_i,
    input  logic [9:0]             position_y_i,
    input  logic                   run_i,
    output logic [NUM_CLIENTS-1:0] update_req_o,
    input  logic [NUM_CLIENTS-1:0] update_ack_i,
    output logic [CW-1:0]          client_idx_o,
    output logic                   frame_tick_o,
    output logic                   busy_o,
    output logic                   timeout_o,
    output logic                   overrun_o,
    output logic [15:0]            frame_count_o
);

    localparam int unsigned DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_CLIENTS-1:0]   req_q, req_d;
    logic [CW-1:0]            idx_q, idx_d;
    logic                     tick_q, tick_d;
    logic                     busy_q, busy_d;
    logic                     timeout_q, timeout_d;
    logic                     overrun_q, overrun_d;
    logic [15:0]              frame_count_q, frame_count_d;
    logic [DW-1:0]            div_cnt_q, div_cnt_d;
    logic [TW-1:0]            to_cnt_q, to_cnt_d;

    logic vb_start;
    logic vis_start;
    logic fire;
    logic ack_active;
    logic to_expired;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        idx_d         = idx_q;
        to_cnt_d      = to_cnt_q;
        div_cnt_d     = div_cnt_q;
        tick_d        = 1'b0;
        timeout_d     = 1'b0;
        overrun_d     = 1'b0;
        fire          = 1'b0;

        vb_start      = (position_x_i == 10'd0) && (position_y_i == 10'(VIS_Y));
        vis_start     = (position_x_i == 10'd0) && (position_y_i == 10'd0);
        ack_active    = update_ack_i[idx_q];
        to_expired    = (to_cnt_q == TW'(TIMEOUT - 1));

        frame_count_d = frame_count_q + 16'(vb_start);

        // Frame divider: held at zero while paused
        if (!run_i) begin
            div_cnt_d = '0;
        end else if (vb_start) begin
            if (div_cnt_q == DW'(FRAME_DIV - 1)) begin
                fire      = 1'b1;
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d  = SERVE;
                    idx_d    = '0;
                    req_d    = NUM_CLIENTS'(1);
                    tick_d   = 1'b1;
                    to_cnt_d = '0;
                end
            end
            SERVE: begin
                // Visible start beats ack and timeout
                if (vis_start) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    req_d     = '0;
                    to_cnt_d  = '0;
                    overrun_d = 1'b1;
                end else if (ack_active || to_expired) begin
                    // An ack on the expiry cycle suppresses the timeout pulse
                    timeout_d = !ack_active;
                    to_cnt_d  = '0;
                    if (idx_q == CW'(NUM_CLIENTS - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        req_d   = '0;
                    end else begin
                        idx_d   = idx_q + CW'(1);
                        req_d   = NUM_CLIENTS'(1) << (idx_q + CW'(1));
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = '0;
                idx_d   = '0;
            end
        endcase

        busy_d = (state_d == SERVE);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            req_q         <= '0;
            idx_q         <= '0;
            tick_q        <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
            div_cnt_q     <= '0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            idx_q         <= idx_d;
            tick_q        <= tick_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
            div_cnt_q     <= div_cnt_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign update_req_o  = req_q;
    assign client_idx_o  = idx_q;
    assign frame_tick_o  = tick_q;
    assign busy_o        = busy_q;
    assign timeout_o     = timeout_q;
    assign overrun_o     = overrun_q;
    assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Bench for frame_update_scheduler. Each frame is planned as a timeline:
// from the chosen ack delays the bench computes when each client's request
// window starts and ends, then drives acks from that plan and checks every
// cycle's outputs against the timeline. A second instance with FRAME_DIV=3
// covers the frame divider.
module tb_frame_update_scheduler;

    localparam int N     = 4;
    localparam int TO    = 16;
    localparam int VIS_Y = 480;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [9:0] px, py;
    logic [3:0] ack_a, ack_b;

    logic [3:0]  req_a, req_b;
    logic [1:0]  idx_a, idx_b;
    logic        tick_a, tick_b, busy_a, busy_b, to_a, to_b, ov_a, ov_b;
    logic [15:0] fc_a, fc_b;

    int checks = 0;
    int errors = 0;
    int fc     = 0;

    always #5 clk = ~clk;

    frame_update_scheduler #(.NUM_CLIENTS(N), .FRAME_DIV(1), .TIMEOUT(TO), .VIS_Y(VIS_Y)) dut_a (
        .clk_i(clk), .rst_i(rst), .position_x_i(px), .position_y_i(py), .run_i(run),
        .update_req_o(req_a), .update_ack_i(ack_a), .client_idx_o(idx_a),
        .frame_tick_o(tick_a), .busy_o(busy_a), .timeout_o(to_a), .overrun_o(ov_a),
        .frame_count_o(fc_a)
    );

    frame_update_scheduler #(.NUM_CLIENTS(N), .FRAME_DIV(3), .TIMEOUT(TO), .VIS_Y(VIS_Y)) dut_b (
        .clk_i(clk), .rst_i(rst), .position_x_i(px), .position_y_i(py), .run_i(run),
        .update_req_o(req_b), .update_ack_i(ack_b), .client_idx_o(idx_b),
        .frame_tick_o(tick_b), .busy_o(busy_b), .timeout_o(to_b), .overrun_o(ov_b),
        .frame_count_o(fc_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Position that is neither vblank start nor visible start
    task automatic idle_pos();
        px = 10'($urandom_range(1, 799));
        py = 10'($urandom_range(0, 524));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame. d[k] = ack delay of client k (-1: never acks).
    // abort_sel >= 0 places a visible start inside the serving window.
    task automatic run_frame(input int d[N], input int abort_sel, input int rst_at,
                             input bit run_vb, input bit stray);
        int s[N+1];
        int len, cut, abort_at;
        logic [3:0] e_req;
        logic [1:0] e_idx;
        logic e_tick, e_busy, e_to, e_ov;
        s[0] = 0;
        for (int k = 0; k < N; k++)
            s[k+1] = s[k] + ((d[k] < 0) ? TO : d[k] + 1);
        len      = run_vb ? s[N] + 3 : 3;
        abort_at = (abort_sel >= 0 && run_vb) ? 1 + (abort_sel % s[N]) : -1;
        cut      = len;
        if (abort_at >= 0) cut = abort_at;
        if (rst_at >= 0 && rst_at < cut) cut = rst_at;
        for (int n = 0; n < len; n++) begin
            rst = (n == rst_at);
            if (n == 0) begin
                px = 10'd0; py = 10'(VIS_Y); run = run_vb;
            end else if (n == abort_at) begin
                px = 10'd0; py = 10'd0; run = 1'($urandom);
            end else begin
                idle_pos(); run = 1'($urandom);
            end
            ack_a = stray ? 4'($urandom) : 4'b0;
            ack_b = 4'hF;
            if (run_vb)
                for (int k = 0; k < N; k++)
                    if (n >= s[k] + 1 && n <= s[k+1])
                        ack_a[k] = (d[k] >= 0) && (n == s[k+1]);
            step();

            if (n == 0) fc = (fc + 1) % 65536;
            if (n == rst_at) fc = 0;
            e_req = '0; e_idx = '0; e_busy = 0; e_tick = 0; e_to = 0;
            if (run_vb && n < cut) begin
                for (int k = 0; k < N; k++) begin
                    if (n >= s[k] && n < s[k+1]) begin
                        e_busy = 1'b1;
                        e_idx  = 2'(k);
                        e_req  = 4'(1 << k);
                    end
                    if (d[k] < 0 && n == s[k+1]) e_to = 1'b1;
                end
                e_tick = (n == 0);
            end
            e_ov = (n == abort_at);
            chk("req",      32'(req_a),  32'(e_req));
            chk("idx",      32'(idx_a),  32'(e_idx));
            chk("busy",     32'(busy_a), 32'(e_busy));
            chk("tick",     32'(tick_a), 32'(e_tick));
            chk("timeout",  32'(to_a),   32'(e_to));
            chk("overrun",  32'(ov_a),   32'(e_ov));
            chk("fcount_a", 32'(fc_a),   32'(fc));
            chk("fcount_b", 32'(fc_b),   32'(fc));
        end
        rst = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; ack_a = '0; ack_b = '0; idle_pos();
        step(); step();
        rst = 1'b0;
        fc  = 0;
        chk("rst_req",  32'(req_a),  32'h0);
        chk("rst_idx",  32'(idx_a),  32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_tick", 32'(tick_a), 32'h0);
        chk("rst_to",   32'(to_a),   32'h0);
        chk("rst_ov",   32'(ov_a),   32'h0);
        chk("rst_fc",   32'(fc_a),   32'h0);
        chk("rst_fc_b", 32'(fc_b),   32'h0);
    endtask

    initial begin
        int dv[N];
        rst = 1'b1; run = 1'b0; px = 10'd5; py = 10'd5; ack_a = '0; ack_b = '0;
        do_reset();

        // Basic sequence, ack each client a few cycles after its request
        dv = '{2, 2, 2, 2};
        run_frame(dv, -1, -1, 1'b1, 1'b0);
        // Client 1 never acks -> skipped by timeout
        dv = '{1, -1, 0, 3};
        run_frame(dv, -1, -1, 1'b1, 1'b0);
        // Ack exactly on the expiry cycle -> no timeout pulse
        dv = '{TO - 1, 0, TO - 1, 0};
        run_frame(dv, -1, -1, 1'b1, 1'b0);
        // Client 2 stalls, visible start aborts the sequence
        dv = '{0, 0, -1, 0};
        run_frame(dv, 4, -1, 1'b1, 1'b0);
        // Visible start on the same cycle as client 1's ack
        dv = '{1, 1, 1, 1};
        run_frame(dv, 3, -1, 1'b1, 1'b0);
        // Stray acks on inactive bits
        dv = '{5, 5, 5, 5};
        run_frame(dv, -1, -1, 1'b1, 1'b1);
        // Paused at vblank start: no tick, count still advances
        run_frame(dv, -1, -1, 1'b0, 1'b1);
        // Reset in the middle of a sequence
        dv = '{3, 3, 3, 3};
        run_frame(dv, -1, 5, 1'b1, 1'b0);

        // Divider: FRAME_DIV=3 instance ticks on the 3rd and 6th vblank start
        do_reset();
        run = 1'b1; ack_a = 4'hF; ack_b = 4'hF;
        for (int v = 1; v <= 7; v++) begin
            px = 10'd0; py = 10'(VIS_Y);
            step();
            fc++;
            chk("div_tick", 32'(tick_b), 32'((v % 3) == 0));
            for (int j = 0; j < 6; j++) begin
                idle_pos();
                step();
                chk("div_quiet", 32'(tick_b), 32'h0);
            end
        end
        chk("div_fc_b", 32'(fc_b), 32'd7);
        chk("div_fc_a", 32'(fc_a), 32'd7);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            int asel;
            for (int k = 0; k < N; k++)
                dv[k] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO - 1));
            asel = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 200)) : -1;
            run_frame(dv, asel, -1, ($urandom_range(0, 7) != 0), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
